// File: rtl/flit_arbiter.sv
// rtl/flit_arbiter.sv - round-robin packet-locked arbiter merging flit queue pop sides onto one registered link

package types;
    typedef logic [31:0] flit_t;
endpackage

module flit_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  types::flit_t [NUM_PORTS-1:0]         in_flit,
    input  logic [NUM_PORTS-1:0]                 in_valid,
    input  logic [NUM_PORTS-1:0]                 in_tail,
    output logic [NUM_PORTS-1:0]                 in_ready,
    output types::flit_t                         out_flit,
    output logic                                 out_tail,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]         out_port,
    output logic                                 locked
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   lock_port;
    logic [PW-1:0]   cand_port;
    logic [PW-1:0]   gnt_port;
    logic            cand_found;
    logic            gnt_valid;
    logic            gnt_tail;
    logic            load_ok;
    logic            in_xfer;
    int              scan_idx;

    // Scan upward from rr_ptr with explicit wrap so non-power-of-two port counts work.
    always_comb begin
        cand_found = 1'b0;
        cand_port  = '0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            if (!cand_found && in_valid[scan_idx[PW-1:0]]) begin
                cand_found = 1'b1;
                cand_port  = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_port  = cand_port;
        gnt_valid = cand_found;
        if (state_q == LOCKED) begin
            // Mid-packet only the owning port may proceed; a gap on it is a bubble.
            gnt_port  = lock_port;
            gnt_valid = in_valid[lock_port];
        end
        load_ok  = !out_valid || out_ready;
        in_xfer  = rst_n && gnt_valid && load_ok;
        gnt_tail = in_tail[gnt_port];
        in_ready = '0;
        if (in_xfer) begin
            in_ready[gnt_port] = 1'b1;
            state_d = gnt_tail ? IDLE : LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            lock_port <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_tail  <= 1'b0;
            out_port  <= '0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                out_flit  <= in_flit[gnt_port];
                out_tail  <= gnt_tail;
                out_port  <= gnt_port;
                out_valid <= 1'b1;
                if (gnt_tail) begin
                    rr_ptr <= (gnt_port == LAST_PORT) ? '0 : gnt_port + PW'(1);
                end else begin
                    lock_port <= gnt_port;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_flit_arbiter.sv
// tb/tb_flit_arbiter.sv - randomized and directed checks of flit_arbiter against a behavioural model

module tb_flit_arbiter;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    types::flit_t [N-1:0] in_flit;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_tail;
    logic [N-1:0]         in_ready;
    types::flit_t         out_flit;
    logic                 out_tail;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_port;
    logic                 locked;

    types::flit_t [2:0]   b_in_flit;
    logic [2:0]           b_in_valid;
    logic [2:0]           b_in_tail;
    logic [2:0]           b_in_ready;
    types::flit_t         b_out_flit;
    logic                 b_out_tail;
    logic                 b_out_valid;
    logic                 b_out_ready;
    logic [1:0]           b_out_port;
    logic                 b_locked;

    flit_arbiter #(.NUM_PORTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_tail  (out_tail),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .locked    (locked)
    );

    flit_arbiter #(.NUM_PORTS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (b_in_flit),
        .in_valid  (b_in_valid),
        .in_tail   (b_in_tail),
        .in_ready  (b_in_ready),
        .out_flit  (b_out_flit),
        .out_tail  (b_out_tail),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_port  (b_out_port),
        .locked    (b_locked)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;

    bit           m_locked;
    int           m_rr;
    int           m_lock;
    bit           m_ov;
    bit           m_tail;
    int           m_port;
    types::flit_t m_flit;
    bit           pkt_open;
    int           pkt_port;
    types::flit_t saved_flit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_rr     = 0;
        m_lock   = 0;
        m_ov     = 1'b0;
        m_tail   = 1'b0;
        m_port   = 0;
        m_flit   = '0;
        pkt_open = 1'b0;
        pkt_port = 0;
    endtask

    function automatic int model_grant();
        if (m_locked) begin
            return in_valid[m_lock] ? m_lock : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive inputs, compare DUT with the model, advance the model across the edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] t, input logic r);
        int         g;
        logic [N-1:0] exp_ready;
        in_valid  = v;
        in_tail   = t;
        out_ready = r;
        for (int i = 0; i < N; i++) in_flit[i] = $urandom;
        #1;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0 && (!m_ov || r)) exp_ready[g] = 1'b1;
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_ov);
        chk("locked", locked, m_locked);
        if (m_ov) begin
            chk("out_flit", out_flit, m_flit);
            chk("out_tail", out_tail, m_tail);
            chk("out_port", out_port, m_port);
        end
        if (out_valid && out_ready) begin
            if (pkt_open) chk("pkt_contig", out_port, pkt_port);
            pkt_open = !out_tail;
            pkt_port = out_port;
        end
        @(posedge clk);
        if (exp_ready != '0) begin
            m_flit = in_flit[g];
            m_tail = t[g];
            m_port = g;
            m_ov   = 1'b1;
            if (t[g]) begin
                m_locked = 1'b0;
                m_rr     = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_lock   = g;
            end
        end else if (m_ov && r) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N-1:0] rt;
        rst_n       = 1'b0;
        in_valid    = 4'b1111;
        in_tail     = 4'b1111;
        out_ready   = 1'b1;
        for (int i = 0; i < N; i++) in_flit[i] = $urandom;
        b_in_valid  = '0;
        b_in_tail   = '0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) b_in_flit[i] = $urandom;
        model_reset();

        @(negedge clk); #1;
        chk("reset_in_ready", in_ready, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_locked", locked, 1'b0);
        @(negedge clk); #1;
        chk("reset_hold_in_ready", in_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_grant", in_ready, 4'b0001);

        for (int k = 0; k < 6; k++) begin
            cycle(4'b1111, 4'b1111, 1'b1);
            chk("rr_port", out_port, 64'(k % 4));
            chk("rr_valid", out_valid, 1'b1);
        end

        cycle(4'b0110, 4'b0010, 1'b1);
        chk("lock_port_a", out_port, 2);
        chk("lock_locked", locked, 1'b1);
        chk("lock_ready", in_ready, 4'b0100);
        cycle(4'b0110, 4'b0010, 1'b1);
        chk("lock_port_b", out_port, 2);
        cycle(4'b0110, 4'b0110, 1'b1);
        chk("lock_port_c", out_port, 2);
        chk("lock_tail", out_tail, 1'b1);
        chk("lock_release", locked, 1'b0);
        cycle(4'b0110, 4'b0110, 1'b1);
        chk("after_lock_port", out_port, 1);

        cycle(4'b1000, 4'b0000, 1'b1);
        chk("bubble_head", out_port, 3);
        chk("bubble_locked", locked, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle(4'b0111, 4'b0111, 1'b1);
            chk("bubble_out_valid", out_valid, 1'b0);
            chk("bubble_in_ready", in_ready, 4'b0000);
            chk("bubble_still_locked", locked, 1'b1);
        end
        cycle(4'b1000, 4'b1000, 1'b1);
        chk("bubble_tail_port", out_port, 3);
        chk("bubble_unlock", locked, 1'b0);
        cycle(4'b0111, 4'b0111, 1'b1);
        chk("bubble_next", out_port, 0);

        cycle(4'b1111, 4'b1111, 1'b1);
        chk("bp_first", out_port, 1);
        saved_flit = out_flit;
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111, 4'b1111, 1'b0);
            chk("bp_port", out_port, 1);
            chk("bp_flit", out_flit, saved_flit);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 4'b0000);
        end
        cycle(4'b1111, 4'b1111, 1'b1);
        chk("bp_resume_port", out_port, 2);
        chk("bp_resume_flit", out_flit, in_flit[2]);

        cycle(4'b1111, 4'b0000, 1'b1);
        chk("mid_reset_pre", locked, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_locked", locked, 1'b0);
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_ready", in_ready, 4'b0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1111, 4'b1111, 1'b1);
        chk("mid_reset_restart", out_port, 0);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = ($urandom_range(0, 9) < 6);
                rt[i] = ($urandom_range(0, 9) < 3);
            end
            cycle(rv, rt, ($urandom_range(0, 9) < 7));
        end

        in_valid   = '0;
        b_in_valid = 3'b100;
        b_in_tail  = 3'b111;
        #1;
        chk("w3_ready_2", b_in_ready, 3'b100);
        @(posedge clk); @(negedge clk);
        chk("w3_port_2", b_out_port, 2);
        chk("w3_valid", b_out_valid, 1'b1);
        b_in_valid = 3'b011;
        #1;
        chk("w3_ready_0", b_in_ready, 3'b001);
        @(posedge clk); @(negedge clk);
        chk("w3_port_0", b_out_port, 0);
        b_in_valid = 3'b110;
        #1;
        chk("w3_ready_1", b_in_ready, 3'b010);
        @(posedge clk); @(negedge clk);
        chk("w3_port_1", b_out_port, 1);
        b_in_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flit_arbiter.md
# flit_arbiter

Round-robin, packet-locked arbiter that merges the pop sides of NUM_PORTS flit_queue instances onto one output flit link. It sits directly downstream of the per-input flit queues and feeds the router output or link stage. It holds a grant from a packet's first flit through its tail flit so packets never interleave. The output is a one-entry registered stage that sustains one flit per cycle under continuous ready.

## Interface
- NUM_PORTS, 4, number of upstream flit queues; legal range 2..16; need not be a power of two.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_flit  input  NUM_PORTS x types::flit_t  flit presented by each upstream queue (its poped_flit).
- in_valid  input  NUM_PORTS  per-port flit valid (queue poped_flit_valid).
- in_tail  input  NUM_PORTS  per-port flag: presented flit is the last flit of its packet; single-flit packets assert it on the only flit.
- in_ready  output  NUM_PORTS  per-port pop accept (drives queue poped_flit_ready); one-hot or zero.
- out_flit  output  types::flit_t  registered output flit.
- out_tail  output  1  registered tail flag accompanying out_flit.
- out_valid  output  1  out_flit/out_tail valid.
- out_ready  input  1  downstream accepts out_flit this cycle.
- out_port  output  $clog2(NUM_PORTS)  source port index of out_flit (registered with it).
- locked  output  1  arbiter is mid-packet (state LOCKED).

## Operation
- Transfer on an input: in_valid[i] && in_ready[i] at a clock edge. Output transfer: out_valid && out_ready.
- load_ok = !out_valid || out_ready; in_ready is 0 on every port when load_ok is 0.
- State IDLE: candidate = first port with in_valid set, scanning from rr_ptr upward with wrap to 0 (mod NUM_PORTS). in_ready[candidate] = load_ok; all other ports 0. No valid port: all in_ready 0.
- State LOCKED: only lock_port is eligible; in_ready[lock_port] = load_ok; others 0 regardless of their in_valid.
- On an input transfer from port p: output register loads in_flit[p], in_tail[p], out_port=p; out_valid=1.
  - in_tail[p]=0: state -> LOCKED, lock_port=p.
  - in_tail[p]=1: state -> IDLE, rr_ptr = (p+1) mod NUM_PORTS.
- rr_ptr changes only on a tail transfer; a head transfer that locks does not move it.
- Output transfer with no input transfer the same cycle: out_valid -> 0. Simultaneous output and input transfer: register reloads; out_valid stays 1.
- out_valid=1 && out_ready=0: out_flit, out_tail, out_port held stable; no input accepted.
- locked = (state == LOCKED).
- LOCKED with in_valid[lock_port]=0: wait indefinitely; no other port is granted (bubble, not a release).
- rr_ptr increment: wrap from NUM_PORTS-1 to 0 via explicit compare, not bit truncation.

## Timing
- Reset (async, immediate): state IDLE, rr_ptr 0, lock_port 0, out_valid 0, out_flit '0, out_tail 0, out_port 0, locked 0; in_ready all 0 while rst_n low.
- in_ready is combinational from in_valid, state, rr_ptr, out_valid, out_ready; no combinational path from in_flit to any output.
- Latency: flit accepted at edge N appears on out_flit with out_valid=1 after edge N; earliest downstream transfer at edge N+1.
- Throughput: 1 flit/cycle with out_ready held 1; back-to-back packets from different ports also sustain 1 flit/cycle (no idle cycle on unlock).
- Reset asserted mid-packet: lock and partial output discarded; after release arbitration restarts from port 0.

## Test plan
- Reset: rst_n low with in_valid=4'b1111 -> in_ready=0, out_valid=0, locked=0; release, out_ready=1 -> port 0 granted first cycle.
- Round robin: all ports present single-flit packets (tail=1), out_ready=1 -> out_port sequence 0,1,2,3,0,... one per cycle, no bubbles.
- Packet lock: port 2 sends 3-flit packet (tail on 3rd), port 1 valid throughout -> out_port 2,2,2 then 1; locked high after first flit until tail accepted; in_ready[1]=0 during lock.
- Lock bubble: port 3 locked, in_valid[3] drops 2 cycles, ports 0-2 valid -> no grant to 0-2, out_valid falls, resumes port 3 until tail.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_flit/out_port stable, all in_ready 0; out_ready=1 -> next flit loaded same edge, no loss or duplication.
- Wrap, NUM_PORTS=3: only port 2 then port 0 valid -> grants 2 then 0; rr_ptr returns to 0 (never 3).
